// File: rtl/rv_multicycle_ctrl.sv
// Multicycle sequencer for the RV32I datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port with variable latency,
// traps on illegal opcodes or memory timeout, and counts retired instructions.
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic [1:0]       operand_sel,
  output logic [1:0]       wrt_data_sel,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Low only in the cycle right after reset, so mem_req rises on the first clock.
  logic             run_q;
  logic [1:0]       exec_sel;
  logic             retire;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // B-operand select chosen by the latched opcode class; also held through MEM
  always_comb begin
    exec_sel = 2'b00;
    case (op_q)
      OP_I, OP_LOAD, OP_JALR: exec_sel = 2'b01;
      OP_STORE:               exec_sel = 2'b10;
      default:                exec_sel = 2'b00;
    endcase
  end

  // Output decode from state/op_q; only mem_ready and branch_taken pass through
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    operand_sel  = 2'b00;
    wrt_data_sel = 2'b00;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = run_q;
        ir_load = run_q & mem_ready;
      end
      S_EXEC: begin
        operand_sel = exec_sel;
        if (op_q == OP_BR) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
        end
      end
      S_MEM: begin
        operand_sel = exec_sel;
        mem_req     = 1'b1;
        mem_we      = (op_q == OP_STORE);
        pc_write    = (op_q == OP_STORE) & mem_ready;
      end
      S_WB: begin
        reg_write    = 1'b1;
        pc_write     = 1'b1;
        pc_src       = (op_q == OP_JAL) || (op_q == OP_JALR);
        wrt_data_sel = (op_q == OP_LOAD) ? 2'b01 :
                       ((op_q == OP_JAL) || (op_q == OP_JALR)) ? 2'b10 : 2'b00;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  // Next-state, memory wait counter and retirement counting
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_req) begin
          if (mem_ready) begin
            wait_d = 8'd0;
            if (state_q == S_FETCH)      state_d = S_DECODE;
            else if (op_q == OP_STORE) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else                     state_d = S_WB;
          end else if (wait_q == WAIT_LIM) begin
            wait_d  = 8'd0;
            state_d = S_TRAP;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = is_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BR: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:           state_d = S_WB;
        endcase
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
    if (retire) cnt_d = cnt_q + 1'b1;
  end

  assign instr_count = cnt_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      wait_q  <= 8'd0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized scoreboard bench for rv_multicycle_ctrl plus directed timeout,
// illegal-opcode and mid-transaction reset scenarios.
module tb_rv_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, ir_load, reg_write, pc_write, pc_src, trap;
  logic [1:0]    operand_sel, wrt_data_sel;
  logic [CW-1:0] instr_count;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
    .operand_sel(operand_sel), .wrt_data_sel(wrt_data_sel), .reg_write(reg_write),
    .pc_write(pc_write), .pc_src(pc_src), .trap(trap), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [1:0] ws;
    logic [1:0] os;
    logic       src;
    int         cnt;
    int         len;
    bit         chk_len;
  } ret_t;
  typedef struct {
    logic       we;
    logic [1:0] os;
  } dat_t;

  ret_t rq[$];
  dat_t dq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1100111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one memory access: answer mem_ready after d idle request cycles.
  // Opcode/branch_taken are switched only once the request is seen, so the
  // previous instruction's EXEC never sees the next instruction's inputs.
  task automatic access(input int d, input logic [6:0] op, input logic tk, output bit ok);
    int n = 0;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (mem_req) begin
        if (n == 0) begin
          opcode       = op;
          branch_taken = tk;
        end
        if (n == d) begin
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          ok = 1'b1;
          return;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    chk("access_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference: per-class expected retirement and data-access behaviour
  task automatic push_model(input int cls, input logic tk, input int df, input int dm,
                            input int cnt, input bit first);
    ret_t r;
    dat_t d;
    r = '{rw: 1'b0, ws: 2'd0, os: 2'd0, src: 1'b0, cnt: cnt % 16, len: 0, chk_len: !first};
    case (cls)
      0, 1: begin r.rw = 1; r.len = 4 + df; end
      2: begin r.rw = 1; r.ws = 2'd1; r.len = 5 + df + dm; d = '{we: 1'b0, os: 2'd1}; dq.push_back(d); end
      3: begin r.os = 2'd2; r.len = 4 + df + dm; d = '{we: 1'b1, os: 2'd2}; dq.push_back(d); end
      4: begin r.src = tk; r.len = 3 + df; end
      default: begin r.rw = 1; r.ws = 2'd2; r.src = 1; r.len = 4 + df; end
    endcase
    rq.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT retires or completes a data access
  initial begin
    int cyc = 0;
    int last = 0;
    ret_t r;
    dat_t d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        chk("no_trap", 32'(trap), 32'd0);
        chk("sel_legal", 32'(operand_sel != 2'b11 && wrt_data_sel != 2'b11), 32'd1);
        chk("pulse_excl", 32'(ir_load && (pc_write || reg_write)), 32'd0);
        chk("rw_needs_pcw", 32'(reg_write && !pc_write), 32'd0);
        if (ir_load) chk("fetch_sel_we", {29'd0, mem_we, operand_sel}, 32'd0);
        if (mem_req && mem_ready && !ir_load) begin
          if (dq.size() == 0) chk("unexpected_data_access", 32'd1, 32'd0);
          else begin
            d = dq.pop_front();
            chk("data_we", 32'(mem_we), 32'(d.we));
            chk("data_operand_sel", 32'(operand_sel), 32'(d.os));
          end
        end
        if (pc_write) begin
          if (rq.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
          else begin
            r = rq.pop_front();
            chk("ret_reg_write", 32'(reg_write), 32'(r.rw));
            chk("ret_wrt_data_sel", 32'(wrt_data_sel), 32'(r.ws));
            chk("ret_operand_sel", 32'(operand_sel), 32'(r.os));
            chk("ret_pc_src", 32'(pc_src), 32'(r.src));
            chk("ret_instr_count", 32'(instr_count), 32'(r.cnt));
            if (r.chk_len) chk("ret_cycles", 32'(cyc - last), 32'(r.len));
          end
          last = cyc;
        end
      end
    end
  end

  initial begin
    bit ok;
    int n;
    int cls, df, dm;
    logic tk;

    // Reset values while reset is held
    #12;
    chk("rst_outputs", {mem_req, mem_we, ir_load, reg_write, pc_write, pc_src, trap,
                        operand_sel, wrt_data_sel}, 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("no_req_before_clock", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("req_after_first_clock", 32'(mem_req), 32'd1);

    // Random instruction stream; 40 retirements wrap the 4-bit counter
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 6);
      tk  = 1'($urandom_range(0, 1));
      df  = $urandom_range(0, 3);
      dm  = $urandom_range(0, 3);
      push_model(cls, tk, df, dm, i, i == 0);
      access(df, ops[cls], tk, ok);
      if (cls == 2 || cls == 3) access(dm, ops[cls], tk, ok);
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("ret_queue_drained", 32'(rq.size()), 32'd0);
    chk("data_queue_drained", 32'(dq.size()), 32'd0);
    chk("count_wrapped", 32'(instr_count), 32'(40 % 16));

    // Timeout in FETCH: trap after TO request cycles
    do_reset();
    n = 0;
    for (int t = 0; t < 20 && !trap; t++) begin
      if (mem_req) n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", 32'(n), 32'(TO));
    chk("timeout_trap", 32'(trap), 32'd1);
    chk("timeout_req_low", 32'(mem_req), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("trap_sticky", {trap, mem_req, pc_write, reg_write, ir_load}, 32'b10000);
    chk("trap_count_frozen", 32'(instr_count), 32'd0);

    // mem_ready on the last allowed cycle wins; then illegal opcode traps
    do_reset();
    access(TO - 1, 7'b1111111, 1'b0, ok);
    chk("limit_ready_no_trap", 32'(trap), 32'd0);
    @(posedge clk); #1;
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_req_low", 32'(mem_req), 32'd0);

    // Reset in the middle of a LOAD's MEM phase
    do_reset();
    access(0, 7'b0110011, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    chk("r_retired", 32'(instr_count), 32'd1);
    access(0, 7'b0000011, 1'b0, ok);
    repeat (2) @(posedge clk);
    #1;
    chk("in_mem_req", {mem_req, mem_we, operand_sel}, 32'b1001);
    reset = 1'b1;
    #1;
    chk("async_rst_outputs", {mem_req, mem_we, ir_load, reg_write, pc_write, trap,
                              operand_sel, wrt_data_sel}, 32'd0);
    chk("async_rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("refetch_after_reset", {mem_req, mem_we, trap}, 32'b100);
    chk("refetch_count", 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I core datapath.
- Drives the ALU B-operand select and register write-back select, plus the memory request handshake, IR load, PC update and register-file write enable.
- Sits between the instruction register / decoder and the operand/write-back muxes, the ALU, the register file and the unified memory port.
- Replaces fixed single-cycle decode, so instruction and data accesses can share one memory port with variable latency.

Parameters:
- MEM_TIMEOUT, 16: max cycles the block waits for mem_ready before trapping; legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  7  IR[6:0]; valid from the DECODE cycle onward.
- branch_taken  input  1  ALU compare result; sampled in EXEC for branches.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held until mem_ready.
- mem_we  output  1  write qualifier; valid while mem_req=1.
- ir_load  output  1  latch memory read data into IR.
- operand_sel  output  2  B-operand mux select: 00 RS2, 01 I-immediate, 10 S-immediate.
- wrt_data_sel  output  2  write-back mux select: 00 ALU out, 01 memory data, 10 PC+4 link.
- reg_write  output  1  register-file write enable.
- pc_write  output  1  PC update strobe.
- pc_src  output  1  0 = PC+4, 1 = ALU target; valid when pc_write=1.
- trap  output  1  sticky illegal-opcode / memory-timeout flag.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async) values:
  - state=FETCH, op_q=0, wait_cnt=0, instr_count=0.
  - All 1-bit outputs 0; operand_sel=00; wrt_data_sel=00.
  - mem_req rises on the first clock after reset deassertion.
  - Reset mid-transaction drops mem_req immediately and discards the instruction.
- Instruction classes (op_q latched in DECODE):
  - R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011.
  - BR = 1100011, JAL = 1101111, JALR = 1100111.
  - Any other opcode is illegal.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_load=1 for that one cycle, next state DECODE.
- DECODE (one cycle):
  - op_q <= opcode.
  - Illegal opcode -> TRAP; else -> EXEC.
- EXEC (one cycle), operand_sel by class:
  - 00 for R and BR.
  - 01 for I, LOAD and JALR.
  - 10 for STORE.
  - 00 for JAL (don't-care, held at 00).
- EXEC next state:
  - R, I, JAL, JALR -> WB.
  - LOAD, STORE -> MEM.
  - BR: pc_write=1, pc_src=branch_taken, instr_count++, next FETCH.
- MEM:
  - operand_sel holds the EXEC value.
  - mem_req=1; mem_we=1 only for STORE.
  - On mem_ready: LOAD -> WB; STORE -> pc_write=1, pc_src=0, instr_count++, next FETCH.
- WB (one cycle):
  - reg_write=1.
  - wrt_data_sel: 00 for R/I, 01 for LOAD, 10 for JAL/JALR.
  - pc_write=1; pc_src=1 for JAL/JALR, else 0.
  - instr_count++; next FETCH.
- Outside EXEC/MEM, operand_sel=00. Outside WB, wrt_data_sel=00. Code 11 is never driven on either select.
- Timeout:
  - wait_cnt increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on leaving FETCH/MEM.
  - When wait_cnt reaches MEM_TIMEOUT-1 with mem_ready still 0: next state TRAP.
  - mem_ready in the same cycle as that limit wins: the access completes, no trap.
- TRAP:
  - trap=1; all strobes and mem_req 0; selects 00.
  - Held until reset; instr_count frozen.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.
- pc_write, reg_write, ir_load are single-cycle pulses; no two of them assert in the same cycle except pc_write with reg_write in WB.
- All outputs are decoded from registered state and op_q; there are no combinational paths from inputs to outputs except mem_ready gating ir_load and the MEM-complete pc_write, and branch_taken gating pc_src.

Test Plan:
- R-type, mem_ready=1 always, opcode=0110011 -> 4 cycles/instr (FETCH, DECODE, EXEC, WB); EXEC operand_sel=00; WB wrt_data_sel=00, reg_write=1, pc_src=0; instr_count=1.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0; operand_sel=01 in EXEC and MEM; WB wrt_data_sel=01; 8 cycles total.
- STORE then JAL -> STORE: operand_sel=10, mem_we=1, no reg_write, pc_write on mem_ready. JAL: WB wrt_data_sel=10, pc_src=1; instr_count=2.
- BR with branch_taken=1, then BR with branch_taken=0 -> pc_write in EXEC with pc_src=1, then pc_src=0; 3 cycles each; reg_write never asserted.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered after 4 request cycles; trap=1, mem_req=0. Repeat with mem_ready=1 on the 4th cycle -> no trap.
- Illegal opcode 1111111 -> TRAP after DECODE. Separately, reset asserted mid-MEM -> outputs 0 asynchronously; after release, FETCH with instr_count=0.
